seq_divide_cell: RTL

Multi-cycle unsigned integer divider: the inverse operation of the team's combinational multiply cell, for the ALU datapath. Computes quotient and remainder of two WIDTH-bit operands by restoring division, one quotient bit per cycle. Uses a start/busy/done handshake with the ALU sequencer. Results are held until the next accepted start.

---
 rtl/div_pkg.sv | 9 +
 rtl/seq_divide_cell_if.sv | 27 ++
 rtl/div_step.sv | 28 ++
 rtl/seq_divide_cell.sv | 86 ++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider
//   state_t       - divider FSM states
//   DEFAULT_WIDTH - default operand/result width
//   CNT_W         - step counter width for the default width
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH);
endpackage

// File: rtl/seq_divide_cell_if.sv
// seq_divide_cell_if: start/busy/done handshake between ALU sequencer and divider
//   master (sequencer): drives start, dividend, divisor; observes results
//   slave  (divider)  : observes request; drives busy, done, quotient, remainder, div_by_zero
interface seq_divide_cell_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
//   rem_in  - current partial remainder (always < divisor)
//   bit_in  - next dividend bit shifted into the trial value
//   divisor - denominator
//   rem_out - new partial remainder
//   q_bit   - quotient bit produced by this step
(* keep_hierarchy = "yes" *)
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] trial;

    // trial is one bit wider so the compare never overflows; the result
    // is below the divisor and therefore fits back into WIDTH bits
    always_comb begin
        trial   = {rem_in, bit_in};
        q_bit   = trial >= {1'b0, divisor};
        rem_out = WIDTH'(q_bit ? trial - {1'b0, divisor} : trial);
    end
endmodule

// File: rtl/seq_divide_cell.sv
// seq_divide_cell: multi-cycle unsigned restoring divider, one quotient bit per cycle
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - slave side of seq_divide_cell_if (start/operands in, busy/done/results out)
module seq_divide_cell
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic              clk,
    input logic              rst,
    seq_divide_cell_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;
    logic             accept;
    logic             last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (sreg[WIDTH-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // DONE accepts a new start just like IDLE, giving back-to-back operation
    always_comb begin
        accept    = state != RUN && bus.start;
        last      = cnt == CW'(WIDTH - 1);
        state_nxt = accept ? (bus.divisor == '0 ? DONE : RUN)
                  : state == RUN ? (last ? DONE : RUN)
                  : IDLE;
    end

    // the shift register starts as the dividend and fills with quotient bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            prem  <= '0;
            sreg  <= '0;
            dvs   <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dvs  <= bus.divisor;
                sreg <= bus.dividend;
                prem <= '0;
                cnt  <= '0;
                dbz  <= bus.divisor == '0;
                if (bus.divisor == '0) begin
                    q <= '1;
                    r <= bus.dividend;
                end
            end else if (state == RUN) begin
                prem <= rem_nxt;
                sreg <= {sreg[WIDTH-2:0], q_bit};
                cnt  <= cnt + 1'b1;
                if (last) begin
                    q <= {sreg[WIDTH-2:0], q_bit};
                    r <= rem_nxt;
                end
            end
        end
    end

    assign bus.busy        = state == RUN;
    assign bus.done        = state == DONE;
    assign bus.quotient    = q;
    assign bus.remainder   = r;
    assign bus.div_by_zero = dbz;
endmodule
